// File: rtl/gates_decoder.sv
// Receiver-side decoder for the {AND, OR, XOR} gate-bank result vector.
// Classifies each accepted vector, recovers the input popcount and keeps saturating per-class statistics.
module gates_decoder #(
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:2]       gate_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_ones,
  output logic             out_legal,
  output logic             err,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_one,
  output logic [CNT_W-1:0] cnt_two,
  output logic [CNT_W-1:0] cnt_err
);

  // State bit 0 mirrors out_valid, bit 1 mirrors halted.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    FULL      = 2'b01,
    HALT      = 2'b10,
    HALT_FULL = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ones_q;
  logic             legal_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q [4];

  logic [1:0] decOnes;
  logic       decLegal;
  logic       accept;
  logic       drain;

  always_comb begin
    decOnes  = 2'd3;
    decLegal = 1'b0;
    case (gate_vec)
      3'b000: begin decOnes = 2'd0; decLegal = 1'b1; end
      3'b011: begin decOnes = 2'd1; decLegal = 1'b1; end
      3'b110: begin decOnes = 2'd2; decLegal = 1'b1; end
      default: begin decOnes = 2'd3; decLegal = 1'b0; end
    endcase
  end

  assign out_valid = (state_q == FULL) || (state_q == HALT_FULL);
  assign halted    = (state_q == HALT) || (state_q == HALT_FULL);
  assign in_ready  = !clr && !halted && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FULL: begin
        if (accept) begin
          state_d = (STOP_ON_ERR && !decLegal) ? HALT_FULL : FULL;
        end else if (drain) begin
          state_d = IDLE;
        end
      end
      HALT_FULL: if (drain) state_d = HALT;
      HALT:      state_d = HALT;
      default:   state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The output data only changes on an accept, so it stays stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q  <= 2'd0;
      legal_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (clr) begin
      ones_q  <= 2'd0;
      legal_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (accept) begin
      ones_q  <= decOnes;
      legal_q <= decLegal;
      if (!decLegal) err_q <= 1'b1;
      if (cnt_q[decOnes] != {CNT_W{1'b1}}) cnt_q[decOnes] <= cnt_q[decOnes] + 1'b1;
    end
  end

  assign out_ones  = ones_q;
  assign out_legal = legal_q;
  assign err       = err_q;
  assign cnt_zero  = cnt_q[0];
  assign cnt_one   = cnt_q[1];
  assign cnt_two   = cnt_q[2];
  assign cnt_err   = cnt_q[3];

endmodule

// File: tb/tb_gates_decoder.sv
// Self-checking bench for gates_decoder: three instances (plain, stop-on-error, 2-bit counters)
// share one stimulus stream and are each compared every cycle against a behavioural model.
module tb_gates_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic [0:2] gate_vec;
  logic       out_ready;

  logic        inReadyA  [3];
  logic        outValidA [3];
  logic        outLegalA [3];
  logic        errA      [3];
  logic        haltedA   [3];
  logic [1:0]  outOnesA  [3];
  logic [31:0] cntA      [3][4];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Instance 0: CNT_W=8 STOP_ON_ERR=0, instance 1: CNT_W=8 STOP_ON_ERR=1, instance 2: CNT_W=2 STOP_ON_ERR=0.
  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int W = (g == 2) ? 2 : 8;
    localparam bit S = (g == 1);
    logic [W-1:0] cz, co, ct, ce;
    logic [1:0]   ones;
    logic         rdy, vld, lgl, er, hlt;

    gates_decoder #(.CNT_W(W), .STOP_ON_ERR(S)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .in_valid (in_valid),
      .in_ready (rdy),
      .gate_vec (gate_vec),
      .out_valid(vld),
      .out_ready(out_ready),
      .out_ones (ones),
      .out_legal(lgl),
      .err      (er),
      .halted   (hlt),
      .cnt_zero (cz),
      .cnt_one  (co),
      .cnt_two  (ct),
      .cnt_err  (ce)
    );

    assign inReadyA[g]  = rdy;
    assign outValidA[g] = vld;
    assign outLegalA[g] = lgl;
    assign errA[g]      = er;
    assign haltedA[g]   = hlt;
    assign outOnesA[g]  = ones;
    assign cntA[g][0]   = 32'(cz);
    assign cntA[g][1]   = 32'(co);
    assign cntA[g][2]   = 32'(ct);
    assign cntA[g][3]   = 32'(ce);
  end

  // Behavioural model state, one slot per instance.
  logic        mValid  [3];
  logic        mHalted [3];
  logic        mErr    [3];
  logic        mLegal  [3];
  logic [1:0]  mOnes   [3];
  int unsigned mCnt    [3][4];
  int unsigned mMax    [3] = '{255, 255, 3};
  bit          mStop   [3] = '{1'b0, 1'b1, 1'b0};

  // Popcount of the gate inputs, found by trying every input pair; 3 marks an unreachable vector.
  function automatic int refOnes(input logic [0:2] v);
    logic [0:2] e;
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        e[0] = 1'(a & b);
        e[1] = 1'(a | b);
        e[2] = 1'(a ^ b);
        if (e == v) return a + b;
      end
    end
    return 3;
  endfunction

  function automatic logic refReady(input int k);
    return !clr && !mHalted[k] && (!mValid[k] || out_ready);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mValid[k] = 1'b0; mHalted[k] = 1'b0; mErr[k] = 1'b0;
      mLegal[k] = 1'b0; mOnes[k] = 2'd0;
      for (int c = 0; c < 4; c++) mCnt[k][c] = 0;
    end
  endtask

  task automatic modelEdge();
    int  cls;
    logic acc;
    for (int k = 0; k < 3; k++) begin
      acc = in_valid && refReady(k);
      if (clr) begin
        mValid[k] = 1'b0; mHalted[k] = 1'b0; mErr[k] = 1'b0;
        mLegal[k] = 1'b0; mOnes[k] = 2'd0;
        for (int c = 0; c < 4; c++) mCnt[k][c] = 0;
      end else begin
        if (mValid[k] && out_ready) mValid[k] = 1'b0;
        if (acc) begin
          cls       = refOnes(gate_vec);
          mValid[k] = 1'b1;
          mOnes[k]  = 2'(cls);
          mLegal[k] = (cls != 3);
          if (mCnt[k][cls] < mMax[k]) mCnt[k][cls]++;
          if (cls == 3) begin
            mErr[k] = 1'b1;
            if (mStop[k]) mHalted[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    string n;
    for (int k = 0; k < 3; k++) begin
      n = $sformatf("d%0d.", k);
      checkOutput({n, "in_ready"},  32'(inReadyA[k]),  32'(refReady(k)));
      checkOutput({n, "out_valid"}, 32'(outValidA[k]), 32'(mValid[k]));
      checkOutput({n, "out_ones"},  32'(outOnesA[k]),  32'(mOnes[k]));
      checkOutput({n, "out_legal"}, 32'(outLegalA[k]), 32'(mLegal[k]));
      checkOutput({n, "err"},       32'(errA[k]),      32'(mErr[k]));
      checkOutput({n, "halted"},    32'(haltedA[k]),   32'(mHalted[k]));
      checkOutput({n, "cnt_zero"},  cntA[k][0], mCnt[k][0]);
      checkOutput({n, "cnt_one"},   cntA[k][1], mCnt[k][1]);
      checkOutput({n, "cnt_two"},   cntA[k][2], mCnt[k][2]);
      checkOutput({n, "cnt_err"},   cntA[k][3], mCnt[k][3]);
    end
  endtask

  // Called just after a rising edge: drive, check before the next edge, then advance the model.
  task automatic applyStimulus(input logic c, input logic v, input logic [0:2] vec, input logic r);
    clr       = c;
    in_valid  = v;
    gate_vec  = vec;
    out_ready = r;
    @(negedge clk);
    checkAll();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  // Asynchronous reset raised in the middle of the high phase; outputs must clear immediately.
  task automatic pulseReset();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  logic [0:2] illegalCodes [5] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b111};

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; gate_vec = 3'b000; out_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    modelEdge();
    #1;
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);

    applyStimulus(1'b0, 1'b1, 3'b000, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b011, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b110, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    checkOutput("legal.cnt_zero", cntA[0][0], 1);
    checkOutput("legal.cnt_one",  cntA[0][1], 1);
    checkOutput("legal.cnt_two",  cntA[0][2], 1);
    checkOutput("legal.err",      32'(errA[0]), 0);

    applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
    foreach (illegalCodes[i]) applyStimulus(1'b0, 1'b1, illegalCodes[i], 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    checkOutput("sweep.cnt_err", cntA[0][3], 5);
    checkOutput("sweep.err",     32'(errA[0]), 1);

    applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b011, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b101, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b1);
    checkOutput("halt.halted",   32'(haltedA[1]), 1);
    checkOutput("halt.cnt_zero", cntA[1][0], 0);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);

    applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b011, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b110, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);

    applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 3'b000, 1'b1);
      if (i == 2) checkOutput("sat.third", cntA[2][0], 3);
    end
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    checkOutput("sat.fifth", cntA[2][0], 3);

    applyStimulus(1'b0, 1'b1, 3'b011, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
    checkOutput("clr.out_valid", 32'(outValidA[0]), 0);

    applyStimulus(1'b0, 1'b1, 3'b110, 1'b0);
    pulseReset();
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulseReset();
      end else begin
        applyStimulus(($urandom_range(0, 99) < 3), ($urandom_range(0, 3) != 0),
                      3'($urandom), ($urandom_range(0, 9) < 7));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
